// File: rtl/stream_arbiter_nport.sv
// N-input AXI-Stream packet arbiter. Merges several event streams into one
// output stream. A source that wins keeps the grant until its tlast beat is
// accepted. Fixed-priority (MODE 0) or round-robin (MODE 1) selection, one
// registered output stage, 1 beat/cycle with full backpressure.
module stream_arbiter_nport #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int MODE      = 0,
  localparam int GW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_s_axis_tdata,
  input  logic [NUM_PORTS-1:0]          i_s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]          i_s_axis_tlast,
  output logic [NUM_PORTS-1:0]          o_s_axis_tready,
  output logic [DATA_W-1:0]             o_m_axis_tdata,
  output logic                          o_m_axis_tvalid,
  output logic                          o_m_axis_tlast,
  input  logic                          i_m_axis_tready,
  output logic [GW-1:0]                 o_grant_id,
  output logic                          o_pkt_active
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_lock_idx;
  logic [GW-1:0]       r_gid_p1;
  logic [DATA_W-1:0]   r_data_p1;
  logic                r_vld_p1;
  logic                r_last_p1;

  logic                       w_slot_free;
  logic                       w_any_valid;
  logic [GW-1:0]              w_ptr_eff;
  logic [2*NUM_PORTS-1:0]     w_dbl;
  logic [NUM_PORTS-1:0]       w_rot;
  logic [GW-1:0]              w_off;
  logic [GW:0]                w_sum;
  logic [GW-1:0]              w_winner;
  logic [GW-1:0]              w_sel_idx;
  logic [NUM_PORTS-1:0]       w_ready;
  logic                       w_accept;
  logic [DATA_W-1:0]          w_sel_data;
  logic                       w_sel_last;
  logic [GW-1:0]              w_ptr_next;

  assign w_slot_free = !r_vld_p1 || i_m_axis_tready;
  assign w_any_valid = |i_s_axis_tvalid;

  // Fixed priority is round-robin with the search origin pinned to port 0.
  assign w_ptr_eff = (MODE == 1) ? r_rr_ptr : '0;
  assign w_dbl     = {i_s_axis_tvalid, i_s_axis_tvalid} >> w_ptr_eff;

  // Winner: first valid port at or above the search origin, with wrap.
  always_comb begin
    w_rot = w_dbl[NUM_PORTS-1:0];
    w_off = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = GW'(k);
    end
    w_sum = {1'b0, w_ptr_eff} + {1'b0, w_off};
    if (w_sum >= (GW+1)'(NUM_PORTS)) w_sum = w_sum - (GW+1)'(NUM_PORTS);
    w_winner = w_sum[GW-1:0];
  end

  assign w_sel_idx = (r_state == ST_IDLE) ? w_winner : r_lock_idx;

  // Per-port ready and the data/last mux of the selected source.
  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_state == ST_IDLE) begin
        w_ready[k] = w_slot_free && w_any_valid && (w_winner == GW'(k));
      end else begin
        w_ready[k] = w_slot_free && (r_lock_idx == GW'(k));
      end
      if (w_sel_idx == GW'(k)) begin
        w_sel_data = i_s_axis_tdata[k*DATA_W +: DATA_W];
        w_sel_last = i_s_axis_tlast[k];
      end
    end
  end

  assign w_accept   = |(i_s_axis_tvalid & w_ready);
  assign w_ptr_next = (w_sel_idx == GW'(NUM_PORTS - 1)) ? '0 : w_sel_idx + GW'(1);

  // Lock FSM, round-robin pointer and the registered output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_vld_p1   <= 1'b0;
      r_data_p1  <= '0;
      r_last_p1  <= 1'b0;
      r_gid_p1   <= '0;
    end else begin
      // ---- stage p1: output register ----
      if (w_slot_free) begin
        if (w_accept) begin
          r_vld_p1  <= 1'b1;
          r_data_p1 <= w_sel_data;
          r_last_p1 <= w_sel_last;
          r_gid_p1  <= w_sel_idx;
        end else begin
          r_vld_p1  <= 1'b0;
        end
      end
      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_sel_last) begin
              r_state    <= ST_LOCKED;
              r_lock_idx <= w_sel_idx;
            end
          end
          ST_LOCKED: begin
            if (w_sel_last) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_sel_last) r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign o_s_axis_tready = w_ready;
  assign o_m_axis_tdata  = r_data_p1;
  assign o_m_axis_tvalid = r_vld_p1;
  assign o_m_axis_tlast  = r_last_p1;
  assign o_grant_id      = r_gid_p1;
  assign o_pkt_active    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_stream_arbiter_nport.sv
// Bench for stream_arbiter_nport. Three instances: A (4 ports, fixed
// priority), B (4 ports, round-robin), C (3 ports, round-robin soak).
// Sources are fed from per-port queues; a monitor checks every delivered beat
// against per-port expected queues and, for directed tests, a global order.
module tb_stream_arbiter_nport;

  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct {
    logic [1:0]    gid;
    logic [DW-1:0] data;
    bit            b2b;
  } ord_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } pexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst_n;
  logic [2:0]    m_rdy;
  logic [3:0]    s_vld  [3];
  logic [3:0]    s_last [3];
  logic [DW-1:0] s_dat  [3][4];

  wire  [3:0]    s_rdy  [3];
  wire  [2:0]    c_srdy;
  wire  [2:0]    m_vld, m_last, m_pkt;
  wire  [DW-1:0] m_dat  [3];
  wire  [1:0]    m_gid  [3];

  wire [4*DW-1:0] tdat_a = {s_dat[0][3], s_dat[0][2], s_dat[0][1], s_dat[0][0]};
  wire [4*DW-1:0] tdat_b = {s_dat[1][3], s_dat[1][2], s_dat[1][1], s_dat[1][0]};
  wire [3*DW-1:0] tdat_c = {s_dat[2][2], s_dat[2][1], s_dat[2][0]};
  assign s_rdy[2] = {1'b0, c_srdy};

  stream_arbiter_nport #(.NUM_PORTS(4), .DATA_W(DW), .MODE(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n[0]),
    .i_s_axis_tdata(tdat_a), .i_s_axis_tvalid(s_vld[0]), .i_s_axis_tlast(s_last[0]),
    .o_s_axis_tready(s_rdy[0]),
    .o_m_axis_tdata(m_dat[0]), .o_m_axis_tvalid(m_vld[0]), .o_m_axis_tlast(m_last[0]),
    .i_m_axis_tready(m_rdy[0]), .o_grant_id(m_gid[0]), .o_pkt_active(m_pkt[0]));

  stream_arbiter_nport #(.NUM_PORTS(4), .DATA_W(DW), .MODE(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n[1]),
    .i_s_axis_tdata(tdat_b), .i_s_axis_tvalid(s_vld[1]), .i_s_axis_tlast(s_last[1]),
    .o_s_axis_tready(s_rdy[1]),
    .o_m_axis_tdata(m_dat[1]), .o_m_axis_tvalid(m_vld[1]), .o_m_axis_tlast(m_last[1]),
    .i_m_axis_tready(m_rdy[1]), .o_grant_id(m_gid[1]), .o_pkt_active(m_pkt[1]));

  stream_arbiter_nport #(.NUM_PORTS(3), .DATA_W(DW), .MODE(1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n[2]),
    .i_s_axis_tdata(tdat_c), .i_s_axis_tvalid(s_vld[2][2:0]), .i_s_axis_tlast(s_last[2][2:0]),
    .o_s_axis_tready(c_srdy),
    .o_m_axis_tdata(m_dat[2]), .o_m_axis_tvalid(m_vld[2]), .o_m_axis_tlast(m_last[2]),
    .i_m_axis_tready(m_rdy[2]), .o_grant_id(m_gid[2]), .o_pkt_active(m_pkt[2]));

  beat_t srcq [3][4][$];
  pexp_t pexp [3][4][$];
  ord_t  ordq [3][$];
  int    np [3] = '{4, 4, 3};
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    n_sent [3] = '{0, 0, 0};
  int    n_dlv  [3] = '{0, 0, 0};
  bit    in_pkt [3];
  logic [1:0] cur_g [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input int i, input int k, input logic [DW-1:0] d, input logic l, input int gap);
    beat_t b;
    pexp_t p;
    b.data = d; b.last = l; b.gap = gap;
    p.data = d; p.last = l;
    srcq[i][k].push_back(b);
    pexp[i][k].push_back(p);
    n_sent[i]++;
  endtask

  task automatic expo(input int i, input logic [1:0] g, input logic [DW-1:0] d, input bit b2b);
    ord_t o;
    o.gid = g; o.data = d; o.b2b = b2b;
    ordq[i].push_back(o);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 3; i++) begin
      if (ordq[i].size() != 0 || m_vld[i]) return 1'b0;
      for (int k = 0; k < 4; k++)
        if (srcq[i][k].size() != 0 || pexp[i][k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input int maxc);
    int t;
    t = 0;
    while (!all_empty() && t < maxc) begin
      tick(1);
      t++;
    end
    n_cmp++;
    if (!all_empty()) begin
      n_err++;
      $display("FAIL %s: traffic still pending after %0d cycles, required all delivered", nm, maxc);
    end
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sources: present queue heads, honour gaps, pop on handshake
  initial begin
    bit fire    [3][4];
    bit started [3][4];
    int gapc    [3][4];
    for (int i = 0; i < 3; i++) begin
      s_vld[i] = '0;
      s_last[i] = '0;
      for (int k = 0; k < 4; k++) begin
        s_dat[i][k] = '0;
        started[i][k] = 1'b0;
        gapc[i][k] = 0;
      end
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 4; k++)
          fire[i][k] = s_vld[i][k] && s_rdy[i][k];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < np[i]; k++) begin
          if (fire[i][k]) begin
            if (srcq[i][k].size() != 0) void'(srcq[i][k].pop_front());
            started[i][k] = 1'b0;
          end
          if (srcq[i][k].size() != 0) begin
            if (!started[i][k]) begin
              gapc[i][k] = srcq[i][k][0].gap;
              started[i][k] = 1'b1;
            end
            if (gapc[i][k] > 0) begin
              gapc[i][k]--;
              s_vld[i][k] = 1'b0;
            end else begin
              s_vld[i][k]  = 1'b1;
              s_dat[i][k]  = srcq[i][k][0].data;
              s_last[i][k] = srcq[i][k][0].last;
            end
          end else begin
            s_vld[i][k] = 1'b0;
          end
        end
      end
    end
  end

  // monitor: checks each delivered beat and output stability under backpressure
  initial begin
    bit            held [3];
    logic [DW-1:0] hd   [3];
    logic          hl   [3];
    logic [1:0]    hg   [3];
    int            last_cyc [3];
    pexp_t         pe;
    ord_t          o;
    logic [1:0]    g;
    for (int i = 0; i < 3; i++) begin
      held[i] = 1'b0;
      in_pkt[i] = 1'b0;
      cur_g[i] = '0;
      last_cyc[i] = -100;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (held[i]) begin
          chk($sformatf("hold_valid[%0d]", i), {63'd0, m_vld[i]}, 64'd1);
          if (m_vld[i]) begin
            chk($sformatf("hold_data[%0d]", i), {48'd0, m_dat[i]}, {48'd0, hd[i]});
            chk($sformatf("hold_last[%0d]", i), {63'd0, m_last[i]}, {63'd0, hl[i]});
            chk($sformatf("hold_gid[%0d]", i), {62'd0, m_gid[i]}, {62'd0, hg[i]});
          end
        end
        if (m_vld[i] && m_rdy[i] && rst_n[i]) begin
          g = m_gid[i];
          n_dlv[i]++;
          n_cmp++;
          if (pexp[i][g].size() == 0) begin
            n_err++;
            $display("FAIL extra_beat[%0d]: port %0d delivered 0x%0h, required nothing pending", i, g, m_dat[i]);
          end else begin
            pe = pexp[i][g].pop_front();
            chk($sformatf("port_data[%0d].p%0d", i, g), {48'd0, m_dat[i]}, {48'd0, pe.data});
            chk($sformatf("port_last[%0d].p%0d", i, g), {63'd0, m_last[i]}, {63'd0, pe.last});
          end
          if (in_pkt[i]) chk($sformatf("interleave[%0d]", i), {62'd0, g}, {62'd0, cur_g[i]});
          in_pkt[i] = !m_last[i];
          cur_g[i] = g;
          if (ordq[i].size() != 0) begin
            o = ordq[i].pop_front();
            chk($sformatf("order_gid[%0d]", i), {62'd0, g}, {62'd0, o.gid});
            chk($sformatf("order_data[%0d]", i), {48'd0, m_dat[i]}, {48'd0, o.data});
            if (o.b2b) chk($sformatf("no_bubble[%0d]", i), 64'(cyc - last_cyc[i]), 64'd1);
          end
          last_cyc[i] = cyc;
        end
        held[i] = m_vld[i] && !m_rdy[i] && rst_n[i];
        hd[i] = m_dat[i];
        hl[i] = m_last[i];
        hg[i] = m_gid[i];
      end
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus and soak
  initial begin
    int t;
    int hi;
    int seq;
    int len;
    rst_n = 3'b000;
    m_rdy = 3'b111;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 3'b111;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid[%0d]", i), {63'd0, m_vld[i]}, 64'd0);
      chk($sformatf("rst_data[%0d]", i), {48'd0, m_dat[i]}, 64'd0);
      chk($sformatf("rst_last[%0d]", i), {63'd0, m_last[i]}, 64'd0);
      chk($sformatf("rst_gid[%0d]", i), {62'd0, m_gid[i]}, 64'd0);
      chk($sformatf("rst_pkt[%0d]", i), {63'd0, m_pkt[i]}, 64'd0);
      chk($sformatf("rst_ready[%0d]", i), {60'd0, s_rdy[i]}, 64'd0);
    end

    // fixed priority: ports 1 and 3 with single-beat packets
    send(0, 1, 16'h0011, 1'b1, 0);
    send(0, 3, 16'h0033, 1'b1, 0);
    expo(0, 2'd1, 16'h0011, 1'b0);
    expo(0, 2'd3, 16'h0033, 1'b1);
    drain("prio_1_3", 50);

    // packet lock: port 2 three beats, port 0 arrives mid-packet
    send(0, 2, 16'h00A0, 1'b0, 0);
    send(0, 2, 16'h00A1, 1'b0, 0);
    send(0, 2, 16'h00A2, 1'b1, 0);
    expo(0, 2'd2, 16'h00A0, 1'b0);
    expo(0, 2'd2, 16'h00A1, 1'b1);
    expo(0, 2'd2, 16'h00A2, 1'b1);
    expo(0, 2'd0, 16'h000B, 1'b1);
    for (t = 0; t < 20 && !m_pkt[0]; t++) tick(1);
    chk("lock_start", {63'd0, m_pkt[0]}, 64'd1);
    send(0, 0, 16'h000B, 1'b1, 0);
    hi = 0;
    while (m_pkt[0] && hi < 20) begin
      hi++;
      chk("lock_ready0", {63'd0, s_rdy[0][0]}, 64'd0);
      tick(1);
    end
    chk("lock_cycles", 64'(hi), 64'd2);
    drain("lock", 50);

    // backpressure: 0x55 held five cycles, port 1 waiting behind it
    m_rdy[0] = 1'b0;
    send(0, 0, 16'h0055, 1'b1, 0);
    send(0, 1, 16'h0066, 1'b1, 0);
    expo(0, 2'd0, 16'h0055, 1'b0);
    expo(0, 2'd1, 16'h0066, 1'b1);
    for (t = 0; t < 20 && !m_vld[0]; t++) tick(1);
    chk("bp_valid", {63'd0, m_vld[0]}, 64'd1);
    repeat (5) begin
      chk("bp_data", {48'd0, m_dat[0]}, 64'h55);
      chk("bp_last", {63'd0, m_last[0]}, 64'd1);
      chk("bp_gid", {62'd0, m_gid[0]}, 64'd0);
      chk("bp_ready", {60'd0, s_rdy[0]}, 64'd0);
      tick(1);
    end
    m_rdy[0] = 1'b1;
    drain("backpressure", 50);

    // round-robin: every port offers single-beat packets
    send(1, 0, 16'h0B00, 1'b1, 0);
    send(1, 0, 16'h0B01, 1'b1, 0);
    send(1, 1, 16'h0B10, 1'b1, 0);
    send(1, 1, 16'h0B11, 1'b1, 0);
    send(1, 2, 16'h0B20, 1'b1, 0);
    send(1, 3, 16'h0B30, 1'b1, 0);
    expo(1, 2'd0, 16'h0B00, 1'b0);
    expo(1, 2'd1, 16'h0B10, 1'b1);
    expo(1, 2'd2, 16'h0B20, 1'b1);
    expo(1, 2'd3, 16'h0B30, 1'b1);
    expo(1, 2'd0, 16'h0B01, 1'b1);
    expo(1, 2'd1, 16'h0B11, 1'b1);
    drain("round_robin", 50);

    // reset while beat 2 of a 4-beat packet sits in the output register
    m_rdy[1] = 1'b0;
    send(1, 2, 16'h00D0, 1'b0, 0);
    send(1, 2, 16'h00D1, 1'b0, 0);
    expo(1, 2'd2, 16'h00D0, 1'b0);
    for (t = 0; t < 20 && !m_vld[1]; t++) tick(1);
    chk("rstpkt_first", {48'd0, m_dat[1]}, 64'hD0);
    m_rdy[1] = 1'b1;
    tick(1);
    m_rdy[1] = 1'b0;
    chk("rstpkt_inflight", {48'd0, m_dat[1]}, 64'hD1);
    chk("rstpkt_locked", {63'd0, m_pkt[1]}, 64'd1);
    rst_n[1] = 1'b0;
    n_sent[1] -= pexp[1][2].size();
    srcq[1][2].delete();
    pexp[1][2].delete();
    in_pkt[1] = 1'b0;
    tick(1);
    rst_n[1] = 1'b1;
    chk("rstpkt_valid", {63'd0, m_vld[1]}, 64'd0);
    chk("rstpkt_pkt", {63'd0, m_pkt[1]}, 64'd0);
    send(1, 1, 16'h00E1, 1'b1, 0);
    send(1, 3, 16'h00E3, 1'b1, 0);
    expo(1, 2'd1, 16'h00E1, 1'b0);
    expo(1, 2'd3, 16'h00E3, 1'b1);
    m_rdy[1] = 1'b1;
    drain("after_reset", 50);

    // soak on 3-port round-robin with random lengths, gaps and ready
    for (int k = 0; k < 3; k++) begin
      seq = 0;
      for (int p = 0; p < 12; p++) begin
        len = int'($urandom_range(1, 8));
        for (int b = 0; b < len; b++) begin
          send(2, k, DW'(k * 4096 + seq), (b == len - 1),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
          seq++;
        end
      end
    end
    for (t = 0; t < 6000 && !all_empty(); t++) begin
      m_rdy[2] = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    m_rdy[2] = 1'b1;
    drain("soak", 200);

    for (int i = 0; i < 3; i++)
      chk($sformatf("beat_count[%0d]", i), 64'(n_dlv[i]), 64'(n_sent[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
